// File: rtl/ex_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_unit
// Purpose  : Iterative radix-2 restoring divide/remainder unit for the EX
//            stage (RV32M DIV, DIVU, REM, REMU). One quotient bit is produced
//            per cycle, MSB first, followed by a sign-fixup cycle. This keeps
//            the combinational divider off the ALU critical path.
// Ports    :
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      request; sampled only when ready==1
//   op         in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a          in   WIDTH  dividend (rs1)
//   b          in   WIDTH  divisor (rs2)
//   flush      in   1      kill of the in-flight operation
//   ready      out  1      IDLE or DONE: a new start is accepted
//   busy       out  1      CALC or SIGN
//   done       out  1      one-cycle pulse, result valid this cycle
//   result     out  WIDTH  quotient or remainder, held until replaced
//   stall_req  out  1      busy | (start & ready & ~flush), to hazard unit
// Revision : 1.0  initial release
// ============================================================================
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             stall_req
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [1:0]         op_q,      op_d;
    logic               neg_quo_q, neg_quo_d;   // quotient must be negated
    logic               neg_rem_q, neg_rem_d;   // remainder must be negated
    logic [WIDTH-1:0]   divisor_q, divisor_d;   // |b|
    logic [WIDTH-1:0]   quot_q,    quot_d;      // |a| shifting out, quotient shifting in
    logic [WIDTH-1:0]   rem_q,     rem_d;       // partial remainder, always < |b|
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   result_q,  result_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_signed_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_rem_shift;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_diff;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_SIGN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign w_accept  = start && ready && !flush;
    assign stall_req = busy || w_accept;

    // Unsigned ops (op[0]==1) ignore operand signs entirely.
    assign w_signed_op = ~op[0];
    assign w_a_neg     = w_signed_op & a[WIDTH-1];
    assign w_b_neg     = w_signed_op & b[WIDTH-1];
    // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude.
    assign w_a_abs     = w_a_neg ? -a : a;
    assign w_b_abs     = w_b_neg ? -b : b;

    // One restoring step. The shifted remainder needs WIDTH+1 bits since it
    // can reach 2*|b|-1. When it is >= |b| the true difference is < |b|, so
    // the low WIDTH bits of the subtraction are exact.
    assign w_rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, divisor_q});
    assign w_rem_diff  = w_rem_shift[WIDTH-1:0] - divisor_q;

    // Sign fixup; the overflow case (-2^(W-1) / -1) lands on 0x80..0 / 0
    // without special handling.
    assign w_quo_fix   = neg_quo_q ? -quot_q : quot_q;
    assign w_rem_fix   = neg_rem_q ? -rem_q  : rem_q;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    op_d = op;
                    if (b == '0) begin
                        // Divide by zero: REM* returns the dividend, DIV* all-ones.
                        result_d = op[1] ? a : '1;
                        state_d  = S_DONE;
                    end else begin
                        neg_quo_d = w_a_neg ^ w_b_neg;
                        neg_rem_d = w_a_neg;
                        divisor_d = w_b_abs;
                        quot_d    = w_a_abs;
                        rem_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_CALC;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                if (w_rem_ge) begin
                    rem_d  = w_rem_diff;
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = w_rem_shift[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_STEP) begin
                    state_d = S_SIGN;
                end
            end

            S_SIGN: begin
                result_d = op_q[1] ? w_rem_fix : w_quo_fix;
                state_d  = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides everything: no done, result left untouched.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_div_unit
// Purpose  : Directed, table-driven self-checking bench for ex_div_unit
//            (WIDTH=32), plus hand-written multi-cycle sequences for flush,
//            back-to-back issue, start-while-busy and mid-operation reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_div_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             stall_req;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex_div_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge with ready high.
    // lat counts sampled cycles after the accepting edge up to and including
    // the one with done high; -1 if done never arrives.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output int busy_cycles);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat         = 1;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        if (!done) lat = -1;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] prev;
        int          lat;
        int          bcy;
        int          seen;

        vecs[0]  = '{2'b00, 32'd100,        32'd25,         32'd4};
        vecs[1]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};
        vecs[4]  = '{2'b11, 32'd5,          32'd0,          32'd5};
        vecs[5]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{2'b01, 32'd1000,       32'd7,          32'd142};
        vecs[8]  = '{2'b11, 32'd1000,       32'd7,          32'd6};
        vecs[9]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[10] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[11] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[12] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[13] = '{2'b11, 32'hFFFF_FFFF,  32'h10,         32'hF};
        vecs[14] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14};
        vecs[15] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE};
        vecs[16] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[17] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",  {31'd0, ready},     32'd1);
        check("reset_busy",   {31'd0, busy},      32'd0);
        check("reset_done",   {31'd0, done},      32'd0);
        check("reset_result", result,             32'd0);
        check("reset_stall",  {31'd0, stall_req}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Combinational stall request while a start is presented in IDLE.
        start = 1'b1;
        #1;
        check("stall_on_start", {31'd0, stall_req}, 32'd1);
        start = 1'b0;
        @(posedge clk); #1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcy);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].b == 32'd0) ? 32'd1 : 32'd34);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcy), (vecs[i].b == 32'd0) ? 32'd0 : 32'd33);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_result_hold", i), result, vecs[i].exp);
        end

        // ---------------- flush mid-operation ----------------
        prev  = result;
        op    = 2'b01;
        a     = 32'd1000;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_after",  {31'd0, busy},  32'd0);
        check("flush_ready_after", {31'd0, ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        check("flush_no_done",     32'(seen), 32'd0);
        check("flush_result_hold", result,    prev);

        // ---------------- flush and start in the same cycle ----------------
        op    = 2'b00;
        a     = 32'd50;
        b     = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_start_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy",   {31'd0, busy}, 32'd0);
        check("flush_start_result", result,        prev);

        // ---------------- back-to-back issue from DONE ----------------
        run_op(2'b01, 32'd9, 32'd3, res, lat, bcy);
        check("b2b_first_result",  res,        32'd3);
        check("b2b_first_latency", 32'(lat),   32'd34);
        check("b2b_ready_in_done", {31'd0, ready}, 32'd1);
        run_op(2'b01, 32'd10, 32'd4, res, lat, bcy);
        check("b2b_second_result",  res,      32'd2);
        check("b2b_second_latency", 32'(lat), 32'd34);
        @(posedge clk); #1;

        // ---------------- start while busy is ignored ----------------
        op    = 2'b01;
        a     = 32'd100;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op    = 2'b00;
        a     = 32'd7;
        b     = 32'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        check("busy_start_result",  result,   32'd33);
        check("busy_start_latency", 32'(lat), 32'd34);
        @(posedge clk); #1;

        // ---------------- asynchronous reset mid-operation ----------------
        run_op(2'b11, 32'd5, 32'd0, res, lat, bcy);   // leaves result nonzero
        check("pre_reset_result", res, 32'd5);
        op    = 2'b00;
        a     = 32'd12345;
        b     = 32'd11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   {31'd0, busy},      32'd0);
        check("midrst_done",   {31'd0, done},      32'd0);
        check("midrst_result", result,             32'd0);
        check("midrst_ready",  {31'd0, ready},     32'd1);
        check("midrst_stall",  {31'd0, stall_req}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
